fir_tap_delay_line: RTL and testbench

Parametrised, load-gated sample delay line for the FIR datapath that replaces the fixed per-tap delay registers with a single TAPS-deep chain. It exposes every tap in parallel to the multiplier array and tracks fill state, so downstream accumulation starts only once the chain holds TAPS valid samples. It sits between the sample input stage and the coefficient multipliers.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_tap_reg.sv | 30 +++
 rtl/fir_tap_delay_line.sv | 102 ++++++++++
 tb/tb_fir_tap_delay_line.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample delay line: default width, fill state
// encoding and the flattened tap slice helper.
package fir_pkg;

  localparam int unsigned DEFAULT_DATAWIDTH = 16;

  typedef enum logic [1:0] {
    StEmpty,
    StFilling,
    StPrimed
  } fill_state_e;

  // LSB position of tap idx within the flattened taps_out bus.
  function automatic int unsigned tap_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fir_tap_reg.sv
// One signed delay-line stage: async reset, synchronous clear, load enable.
module fir_tap_reg
  import fir_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        load,
  input  logic signed [DATAWIDTH-1:0] d,
  output logic signed [DATAWIDTH-1:0] q
);

  logic signed [DATAWIDTH-1:0] q_q;

  // Clear wins over load so a flushed sample never enters the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fir_tap_delay_line.sv
// TAPS-deep load-gated sample delay line with parallel tap outputs and fill
// tracking so downstream accumulation waits until the chain is full.
module fir_tap_delay_line
  import fir_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int unsigned TAPS      = 3,
  localparam int unsigned CNT_W    = $clog2(TAPS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATAWIDTH-1:0] din,
  input  logic                        shift_en,
  input  logic                        flush,
  output logic [TAPS*DATAWIDTH-1:0]   taps_out,
  output logic [CNT_W-1:0]            fill_cnt,
  output logic                        primed,
  output logic                        shift_valid
);

  logic                        shift;
  logic signed [DATAWIDTH-1:0] tap_q [TAPS];

  fill_state_e      state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             shift_valid_q;

  assign shift = shift_en & ~flush;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [DATAWIDTH-1:0] tap_d;

    if (k == 0) begin : g_head
      assign tap_d = din;
    end else begin : g_body
      assign tap_d = tap_q[k-1];
    end

    fir_tap_reg #(
      .DATAWIDTH(DATAWIDTH)
    ) u_tap (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .load(shift),
      .d   (tap_d),
      .q   (tap_q[k])
    );

    assign taps_out[tap_lsb(k, DATAWIDTH) +: DATAWIDTH] = tap_q[k];
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (flush) begin
      state_d    = StEmpty;
      fill_cnt_d = '0;
    end else if (shift_en) begin
      unique case (state_q)
        StEmpty: begin
          state_d    = StFilling;
          fill_cnt_d = CNT_W'(1);
        end
        StFilling: begin
          if (fill_cnt_q == CNT_W'(TAPS - 1)) begin
            state_d    = StPrimed;
            fill_cnt_d = CNT_W'(TAPS);
          end else begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
          end
        end
        StPrimed: begin
          // Saturate: further shifts only move data, the count stays at TAPS.
          state_d    = StPrimed;
          fill_cnt_d = CNT_W'(TAPS);
        end
        default: begin
          state_d    = StEmpty;
          fill_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StEmpty;
      fill_cnt_q    <= '0;
      shift_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      shift_valid_q <= shift;
    end
  end

  assign fill_cnt    = fill_cnt_q;
  assign primed      = (state_q == StPrimed);
  assign shift_valid = shift_valid_q;

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// Scoreboard bench for fir_tap_delay_line: a 3x16 and an 8x12 instance.
module tb_fir_tap_delay_line;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: TAPS = 3, DATAWIDTH = 16
  logic signed [15:0] din_a = '0;
  logic               shift_en_a = 1'b0;
  logic               flush_a = 1'b0;
  logic [47:0]        taps_out_a;
  logic [1:0]         fill_cnt_a;
  logic               primed_a;
  logic               shift_valid_a;

  // Instance B: TAPS = 8, DATAWIDTH = 12
  logic signed [11:0] din_b = '0;
  logic               shift_en_b = 1'b0;
  logic               flush_b = 1'b0;
  logic [95:0]        taps_out_b;
  logic [3:0]         fill_cnt_b;
  logic               primed_b;
  logic               shift_valid_b;

  fir_tap_delay_line #(
    .DATAWIDTH(16),
    .TAPS     (3)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .din        (din_a),
    .shift_en   (shift_en_a),
    .flush      (flush_a),
    .taps_out   (taps_out_a),
    .fill_cnt   (fill_cnt_a),
    .primed     (primed_a),
    .shift_valid(shift_valid_a)
  );

  fir_tap_delay_line #(
    .DATAWIDTH(12),
    .TAPS     (8)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .din        (din_b),
    .shift_en   (shift_en_b),
    .flush      (flush_b),
    .taps_out   (taps_out_b),
    .fill_cnt   (fill_cnt_b),
    .primed     (primed_b),
    .shift_valid(shift_valid_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ma [3];
  int          ma_cnt = 0;
  logic [47:0] q_a [$];
  logic [11:0] mb [8];
  int          mb_cnt = 0;
  logic [95:0] q_b [$];

  function automatic logic [47:0] flat_a();
    logic [47:0] r;
    for (int k = 0; k < 3; k++) r[k*16 +: 16] = ma[k];
    return r;
  endfunction

  function automatic logic [95:0] flat_b();
    logic [95:0] r;
    for (int k = 0; k < 8; k++) r[k*12 +: 12] = mb[k];
    return r;
  endfunction

  function automatic logic [47:0] pop_a();
    if (q_a.size() == 0) return 'x;
    return q_a.pop_front();
  endfunction

  function automatic logic [95:0] pop_b();
    if (q_b.size() == 0) return 'x;
    return q_b.pop_front();
  endfunction

  task automatic clear_model_a();
    for (int k = 0; k < 3; k++) ma[k] = '0;
    ma_cnt = 0;
    q_a.delete();
  endtask

  // Drive one cycle on A, then advance the reference model past the edge.
  task automatic drive_a(input logic sh, input logic [15:0] d, input logic fl);
    shift_en_a = sh;
    din_a      = d;
    flush_a    = fl;
    @(posedge clk);
    #1;
    shift_en_a = 1'b0;
    flush_a    = 1'b0;
    if (fl) begin
      for (int k = 0; k < 3; k++) ma[k] = '0;
      ma_cnt = 0;
    end else if (sh) begin
      for (int k = 2; k > 0; k--) ma[k] = ma[k-1];
      ma[0] = d;
      if (ma_cnt < 3) ma_cnt++;
      q_a.push_back(flat_a());
    end
  endtask

  task automatic drive_b(input logic sh, input logic [11:0] d);
    shift_en_b = sh;
    din_b      = d;
    @(posedge clk);
    #1;
    shift_en_b = 1'b0;
    if (sh) begin
      for (int k = 7; k > 0; k--) mb[k] = mb[k-1];
      mb[0] = d;
      if (mb_cnt < 8) mb_cnt++;
      q_b.push_back(flat_b());
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (taps_out_a !== '0 || fill_cnt_a !== '0 || primed_a !== 1'b0 || shift_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a: taps=%h cnt=%0d primed=%b sv=%b, required all zero",
               taps_out_a, fill_cnt_a, primed_a, shift_valid_a);
    end
    n_cmp++;
    if (taps_out_b !== '0 || fill_cnt_b !== '0 || primed_b !== 1'b0 || shift_valid_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b: taps=%h cnt=%0d primed=%b sv=%b, required all zero",
               taps_out_b, fill_cnt_b, primed_b, shift_valid_b);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model_a();
    for (int k = 0; k < 8; k++) mb[k] = '0;
  endtask

  task automatic test_fill();
    logic [15:0] vals [3];
    logic [47:0] exp;
    vals[0] = 16'd5;
    vals[1] = 16'hFFF9;
    vals[2] = 16'h7FFF;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, vals[i], 1'b0);
      exp = pop_a();
      n_cmp++;
      if (shift_valid_a !== 1'b1 || taps_out_a !== exp) begin
        n_err++;
        $display("FAIL fill_shift%0d: sv=%b taps=%h, required sv=1 taps=%h",
                 i, shift_valid_a, taps_out_a, exp);
      end
      n_cmp++;
      if (fill_cnt_a !== 2'(i + 1) || primed_a !== (i == 2)) begin
        n_err++;
        $display("FAIL fill_cnt%0d: cnt=%0d primed=%b, required cnt=%0d primed=%b",
                 i, fill_cnt_a, primed_a, i + 1, (i == 2));
      end
    end
    n_cmp++;
    if (taps_out_a !== 48'h0005_FFF9_7FFF) begin
      n_err++;
      $display("FAIL fill_final: taps=%h, required 0005fff97fff", taps_out_a);
    end
  endtask

  task automatic test_gaps();
    logic [47:0] exp;
    drive_a(1'b0, '0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 16'(i), 1'b0);
      exp = pop_a();
      n_cmp++;
      if (shift_valid_a !== 1'b1 || taps_out_a !== exp || fill_cnt_a !== 2'(ma_cnt)) begin
        n_err++;
        $display("FAIL gap_shift%0d: sv=%b taps=%h cnt=%0d, required sv=1 taps=%h cnt=%0d",
                 i, shift_valid_a, taps_out_a, fill_cnt_a, exp, ma_cnt);
      end
      drive_a(1'b0, 16'h1234, 1'b0);
      n_cmp++;
      if (shift_valid_a !== 1'b0 || taps_out_a !== flat_a() || fill_cnt_a !== 2'(ma_cnt)) begin
        n_err++;
        $display("FAIL gap_idle%0d: sv=%b taps=%h cnt=%0d, required sv=0 taps=%h cnt=%0d",
                 i, shift_valid_a, taps_out_a, fill_cnt_a, flat_a(), ma_cnt);
      end
    end
    n_cmp++;
    if (taps_out_a !== 48'h0002_0003_0004 || primed_a !== 1'b1) begin
      n_err++;
      $display("FAIL gap_final: taps=%h primed=%b, required 000200030004 primed=1",
               taps_out_a, primed_a);
    end
  endtask

  task automatic test_flush_shift();
    drive_a(1'b1, 16'd99, 1'b1);
    n_cmp++;
    if (taps_out_a !== '0 || fill_cnt_a !== '0 || primed_a !== 1'b0 || shift_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL flush_shift: taps=%h cnt=%0d primed=%b sv=%b, required all zero",
               taps_out_a, fill_cnt_a, primed_a, shift_valid_a);
    end
    drive_a(1'b0, '0, 1'b0);
    drive_a(1'b0, '0, 1'b0);
    n_cmp++;
    if (taps_out_a !== '0 || fill_cnt_a !== '0) begin
      n_err++;
      $display("FAIL flush_hold: taps=%h cnt=%0d, required zero", taps_out_a, fill_cnt_a);
    end
  endtask

  task automatic test_async_rst();
    logic [47:0] exp;
    drive_a(1'b1, 16'd10, 1'b0);
    drive_a(1'b1, 16'd20, 1'b0);
    void'(pop_a());
    void'(pop_a());
    n_cmp++;
    if (fill_cnt_a !== 2'd2) begin
      n_err++;
      $display("FAIL arst_pre: cnt=%0d, required 2", fill_cnt_a);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (taps_out_a !== '0 || fill_cnt_a !== '0 || primed_a !== 1'b0 || shift_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL arst_now: taps=%h cnt=%0d primed=%b sv=%b, required all zero",
               taps_out_a, fill_cnt_a, primed_a, shift_valid_a);
    end
    #1 rst = 1'b0;
    clear_model_a();
    drive_a(1'b1, 16'd7, 1'b0);
    exp = pop_a();
    n_cmp++;
    if (fill_cnt_a !== 2'd1 || taps_out_a !== exp || exp !== 48'h0000_0000_0007) begin
      n_err++;
      $display("FAIL arst_first: cnt=%0d taps=%h, required cnt=1 taps=%h", fill_cnt_a,
               taps_out_a, 48'h7);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp;
    logic [11:0] want;
    int          bad;
    for (int i = 0; i < 20; i++) begin
      drive_b(1'b1, 12'(-2048 + i));
      exp = pop_b();
      n_cmp++;
      if (shift_valid_b !== 1'b1 || taps_out_b !== exp || fill_cnt_b !== 4'(mb_cnt) ||
          primed_b !== (mb_cnt == 8)) begin
        n_err++;
        $display("FAIL b2b_shift%0d: sv=%b taps=%h cnt=%0d primed=%b, required taps=%h cnt=%0d",
                 i, shift_valid_b, taps_out_b, fill_cnt_b, primed_b, exp, mb_cnt);
      end
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      want = 12'(-2029 - k);
      if (taps_out_b[k*12 +: 12] !== want || taps_out_b[k*12 + 11] !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || fill_cnt_b !== 4'd8) begin
      n_err++;
      $display("FAIL b2b_final: %0d bad taps, cnt=%0d, taps=%h, required cnt=8 taps -2029..-2036",
               bad, fill_cnt_b, taps_out_b);
    end
    drive_b(1'b0, '0);
    n_cmp++;
    if (shift_valid_b !== 1'b0 || taps_out_b !== flat_b()) begin
      n_err++;
      $display("FAIL b2b_idle: sv=%b taps=%h, required sv=0 taps=%h", shift_valid_b,
               taps_out_b, flat_b());
    end
  endtask

  task automatic test_min_value();
    logic [47:0] exp;
    drive_a(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 16'h8000, 1'b0);
      exp = pop_a();
      n_cmp++;
      if (taps_out_a !== exp) begin
        n_err++;
        $display("FAIL minval_shift%0d: taps=%h, required %h", i, taps_out_a, exp);
      end
    end
    n_cmp++;
    if (taps_out_a !== 48'h8000_8000_8000 || fill_cnt_a !== 2'd3) begin
      n_err++;
      $display("FAIL minval_final: taps=%h cnt=%0d, required 800080008000 cnt=3", taps_out_a,
               fill_cnt_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_gaps();
    test_flush_shift();
    test_async_rst();
    test_back_to_back();
    test_min_value();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
